// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline forwarding/stall unit with a multicycle-op tracker
// Optional HAZARD_STATS_EN adds saturating stall_cnt/mc_cnt counters.
module hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int MC_LAT  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_mc,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_regwrite,
    input  logic                      ex_memread,
    input  logic                      ex_mc,
    input  logic [REG_AW-1:0]         mem_rd,
    input  logic                      mem_regwrite,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic                      wb_regwrite,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      flush_ex,
    output logic                      mc_busy,
    output logic                      mc_done,
    output logic [REG_AW-1:0]         mc_rd
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]               stall_cnt,
    output logic [15:0]               mc_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(MC_LAT - 2);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [REG_AW-1:0] mc_rd_q, mc_rd_d;
    logic              mc_issue, mc_pending;
    logic              load_use, mc_raw, mc_waw, mc_struct;

    assign mc_issue   = ex_mc && ex_regwrite;
    assign mc_busy    = (state_q == S_BUSY) || (state_q == S_DONE);
    assign mc_done    = (state_q == S_DONE);
    assign mc_rd      = mc_rd_q;
    assign mc_pending = mc_busy && !mc_done;

    // DONE is the MC_LAT-th cycle after capture: MC_LAT-1 BUSY cycles, counter MC_LAT-2..0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_rd_d = mc_rd_q;
        case (state_q)
            S_IDLE: begin
                if (mc_issue) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                    mc_rd_d = ex_rd;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (mc_issue) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                    mc_rd_d = ex_rd;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            mc_rd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_rd_q <= mc_rd_d;
        end
    end

    always_comb begin
        load_use = 1'b0;
        mc_raw   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ex_memread && (ex_rd != '0) && (ex_rd == id_rs[k*REG_AW +: REG_AW]))
                load_use = 1'b1;
            if (mc_pending && (mc_rd_q != '0) && (mc_rd_q == id_rs[k*REG_AW +: REG_AW]))
                mc_raw = 1'b1;
        end
    end

    assign mc_waw    = mc_pending && id_regwrite && (id_rd == mc_rd_q) && (id_rd != '0);
    assign mc_struct = id_mc && mc_pending;
    assign stall     = load_use || mc_raw || mc_waw || mc_struct;
    assign flush_ex  = stall;

    always_comb begin
        fwd_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ex_rs[k*REG_AW +: REG_AW] != '0) begin
                if (mem_regwrite && (mem_rd == ex_rs[k*REG_AW +: REG_AW]))
                    fwd_sel[2*k +: 2] = 2'b10;
                else if (wb_regwrite && (wb_rd == ex_rs[k*REG_AW +: REG_AW]))
                    fwd_sel[2*k +: 2] = 2'b01;
                else if (mc_done && (mc_rd_q == ex_rs[k*REG_AW +: REG_AW]))
                    fwd_sel[2*k +: 2] = 2'b11;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, mc_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            mc_cnt_q    <= 16'd0;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (mc_done && (mc_cnt_q != 16'hFFFF))
                mc_cnt_q <= mc_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign mc_cnt    = mc_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  id_rs, ex_rs;
    logic [4:0]  id_rd, ex_rd, mem_rd, wb_rd;
    logic        id_regwrite, id_mc, ex_regwrite, ex_memread, ex_mc;
    logic        mem_regwrite, wb_regwrite;
    logic [3:0]  fwd_sel;
    logic        stall, flush_ex, mc_busy, mc_done;
    logic [4:0]  mc_rd;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, mc_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_unit #(.NUM_SRC(2), .REG_AW(5), .MC_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_mc(id_mc),
        .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_mc(ex_mc),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .fwd_sel(fwd_sel), .stall(stall), .flush_ex(flush_ex),
        .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd(mc_rd)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .mc_cnt(mc_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rd = '0; id_regwrite = 0; id_mc = 0;
        ex_rs = '0; ex_rd = '0; ex_regwrite = 0; ex_memread = 0; ex_mc = 0;
        mem_rd = '0; mem_regwrite = 0; wb_rd = '0; wb_regwrite = 0;
    endtask

    task automatic issue_mc(input logic [4:0] rd);
        ex_mc = 1; ex_regwrite = 1; ex_rd = rd;
        tick();
        ex_mc = 0; ex_regwrite = 0; ex_rd = '0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        #1;
        chk("rst_busy", 32'(mc_busy), 0);
        chk("rst_done", 32'(mc_done), 0);
        chk("rst_mc_rd", 32'(mc_rd), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd", 32'(fwd_sel), 0);
        tick();
        tick();
        rst_n = 1;
        tick();

`ifdef HAZARD_STATS_EN
        chk("stats_rst_stall", 32'(stall_cnt), 0);
        chk("stats_rst_mc", 32'(mc_cnt), 0);
        for (int op = 0; op < 2; op++) begin
            issue_mc(5'd9);
            for (int c = 0; c < 4; c++) tick();
        end
        ex_memread = 1; ex_rd = 5'd7; id_rs = {5'd7, 5'd0};
        tick(); tick(); tick();
        clear_inputs();
        #1;
        chk("stats_stall_cnt", 32'(stall_cnt), 3);
        chk("stats_mc_cnt", 32'(mc_cnt), 2);
        ex_memread = 1; ex_rd = 5'd7; id_rs = {5'd7, 5'd0};
        for (int c = 0; c < 65540; c++) tick();
        clear_inputs();
        #1;
        chk("stats_stall_sat", 32'(stall_cnt), 32'hFFFF);
        rst_n = 0;
        #1;
        chk("stats_rst_again", 32'(stall_cnt), 0);
        tick();
        rst_n = 1;
        tick();
`endif

        // forwarding priority
        ex_rs = {5'd0, 5'd3}; mem_rd = 5'd3; wb_rd = 5'd3;
        mem_regwrite = 1; wb_regwrite = 1;
        #1;
        chk("fwd_memwb_prio", 32'(fwd_sel), 32'b0010);
        mem_regwrite = 0;
        #1;
        chk("fwd_wb", 32'(fwd_sel), 32'b0001);
        ex_rs = '0; mem_rd = '0; wb_rd = '0; mem_regwrite = 1; wb_regwrite = 1;
        #1;
        chk("fwd_r0_none", 32'(fwd_sel), 32'b0000);
        ex_rs = {5'd4, 5'd3}; mem_rd = 5'd4; wb_rd = 5'd3;
        #1;
        chk("fwd_two_slots", 32'(fwd_sel), 32'b1001);
        clear_inputs();

        // load-use
        ex_memread = 1; ex_rd = 5'd7; id_rs = {5'd7, 5'd0};
        #1;
        chk("lu_stall", 32'(stall), 1);
        chk("lu_flush", 32'(flush_ex), 1);
        ex_rd = 5'd0;
        #1;
        chk("lu_rd0", 32'(stall), 0);
        ex_rd = 5'd7; ex_memread = 0;
        #1;
        chk("lu_no_memread", 32'(stall), 0);
        clear_inputs();

        // ex_mc without regwrite ignored
        ex_mc = 1; ex_rd = 5'd5;
        tick();
        clear_inputs();
        #1;
        chk("mc_no_rw_ignored", 32'(mc_busy), 0);

        // multicycle latency, RAW/WAW/structural
        id_rs = {5'd0, 5'd9};
        #1;
        chk("pre_issue_stall", 32'(stall), 0);
        issue_mc(5'd9);
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("busy_c%0d", c), 32'(mc_busy), 1);
            chk($sformatf("nodone_c%0d", c), 32'(mc_done), 0);
            chk($sformatf("raw_stall_c%0d", c), 32'(stall), 1);
            if (c == 2) begin
                chk("mc_rd_held", 32'(mc_rd), 9);
                id_rs = '0; id_rd = 5'd9; id_regwrite = 1;
                #1;
                chk("waw_stall", 32'(stall), 1);
                id_regwrite = 0; id_mc = 1;
                #1;
                chk("struct_stall", 32'(stall), 1);
                id_mc = 0; id_rs = {5'd0, 5'd9};
            end
            tick();
        end
        #1;
        chk("done_c4", 32'(mc_done), 1);
        chk("done_busy_c4", 32'(mc_busy), 1);
        chk("done_no_raw", 32'(stall), 0);
        id_rd = 5'd9; id_regwrite = 1; id_mc = 1;
        #1;
        chk("done_no_waw_struct", 32'(stall), 0);
        ex_rs = {5'd0, 5'd9};
        #1;
        chk("fwd_mc", 32'(fwd_sel), 32'b0011);
        clear_inputs();

        // back-to-back issue in DONE
        ex_mc = 1; ex_regwrite = 1; ex_rd = 5'd12;
        tick();
        clear_inputs();
        #1;
        chk("b2b_busy", 32'(mc_busy), 1);
        chk("b2b_nodone", 32'(mc_done), 0);
        chk("b2b_rd", 32'(mc_rd), 12);
        tick();
        rst_n = 0;
        #1;
        chk("rst_mid_busy", 32'(mc_busy), 0);
        chk("rst_mid_rd", 32'(mc_rd), 0);
        tick();
        rst_n = 1;
        begin
            int done_seen = 0;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (mc_done) done_seen++;
            end
            chk("rst_no_done", 32'(done_seen), 0);
        end

        // plain op returns to IDLE after DONE
        issue_mc(5'd6);
        tick(); tick(); tick();
        #1;
        chk("op2_done", 32'(mc_done), 1);
        tick();
        #1;
        chk("op2_idle", 32'(mc_busy), 0);
        chk("op2_rd_hold", 32'(mc_rd), 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
